// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types for the fetch-address sequencer.
//   pc_sel_e    - source selected for the next PC
//   seq_state_e - sequencer run state
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET,
    SEL_HOLD
  } pc_sel_e;

  typedef enum logic {
    RUN,
    HALTED
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_seq_if: request/status bundle between the fetch front end and pc_sequencer.
//   master : drives stall/halt/restart and redirect requests, observes PC and stack status
//   slave  : the sequencer; consumes requests, drives pc, pc_next, halted and stack flags
interface pc_seq_if #(
  parameter int unsigned PC_WIDTH = 32
) ();

  logic                stall;
  logic                halt;
  logic                restart;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump;
  logic                call;
  logic [PC_WIDTH-1:0] jump_target;
  logic                ret;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic                halted;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_underflow;

  modport master (
    output stall, halt, restart, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc, pc_next, halted, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, halt, restart, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc, pc_next, halted, ras_empty, ras_full, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: circular return-address stack.
//   clk, reset_n     - clock, async active-low reset (clears count/pointer only)
//   push, push_data  - write push_data at top+1 and advance top; overwrites oldest when full
//   pop              - retreat top; ignored when empty
//   clear            - drop all entries (takes precedence over push/pop)
//   top_data         - entry at top (valid when !empty)
//   empty, full      - count == 0 / count == DEPTH
module return_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_inc;
  logic             w_push;
  logic             w_pop;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_push    = push && !clear;
  assign w_pop     = pop && !clear && !empty;

  assign top_data = r_mem[r_top];
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_push) begin
      r_top <= w_top_inc;
      // Saturate: a push when full silently replaces the oldest entry.
      if (!full) r_count <= r_count + CNT_W'(1);
    end else if (w_pop) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry contents need no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_top_inc] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register with internal next-PC selection.
//   clk, reset_n - clock, async active-low reset
//   bus (slave)  - stall/halt/restart, branch/jump/call/ret requests in;
//                  pc (registered), pc_next (combinational), halted, ras_* status out
// Next-PC priority in RUN without stall: call > jump > ret > branch > increment.
// Lower-priority requests in the same cycle are dropped with no stack side effects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         PC_INC    = 1,
  parameter int unsigned         RAS_DEPTH = 4
) (
  input logic   clk,
  input logic   reset_n,
  pc_seq_if.slave bus
);

  seq_state_e          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_halted;
  logic                r_underflow;

  pc_sel_e             w_sel;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_top_data;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_uf_set;
  logic                w_restart;

  assign w_pc_inc  = r_pc + PC_WIDTH'(PC_INC);
  assign w_restart = (r_state == HALTED) && bus.restart;

  always_comb begin
    w_sel = SEL_INC;
    if (r_state == HALTED || bus.stall) w_sel = SEL_HOLD;
    else if (bus.call)                  w_sel = SEL_CALL;
    else if (bus.jump)                  w_sel = SEL_JUMP;
    else if (bus.ret)                   w_sel = SEL_RET;
    else if (bus.branch_taken)          w_sel = SEL_BRANCH;
  end

  always_comb begin
    w_pc_next = r_pc;
    unique case (w_sel)
      SEL_CALL,
      SEL_JUMP:   w_pc_next = bus.jump_target;
      // Return with an empty stack falls through to sequential fetch.
      SEL_RET:    w_pc_next = w_empty ? w_pc_inc : w_top_data;
      SEL_BRANCH: w_pc_next = bus.branch_target;
      SEL_INC:    w_pc_next = w_pc_inc;
      SEL_HOLD:   w_pc_next = w_restart ? RESET_PC : r_pc;
      default:    w_pc_next = r_pc;
    endcase
  end

  assign w_push   = (w_sel == SEL_CALL);
  assign w_pop    = (w_sel == SEL_RET) && !w_empty;
  assign w_uf_set = (w_sel == SEL_RET) && w_empty;

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (w_restart),
    .push_data (w_pc_inc),
    .top_data  (w_top_data),
    .empty     (w_empty),
    .full      (w_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_halted    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // w_pc_next already equals r_pc when stalled.
          r_pc <= w_pc_next;
          if (w_uf_set) r_underflow <= 1'b1;
          if (bus.halt && !bus.stall) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          if (bus.restart) begin
            r_state     <= RUN;
            r_halted    <= 1'b0;
            r_pc        <= RESET_PC;
            r_underflow <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_next       = w_pc_next;
  assign bus.halted        = r_halted;
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_full;
  assign bus.ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (PC_WIDTH=8, RESET_PC=0, PC_INC=1, RAS_DEPTH=4).
module tb_pc_sequencer;

  localparam int unsigned W = 8;

  // Request bits: {stall, halt, restart, call, jump, ret, branch_taken}
  localparam logic [6:0] N   = 7'h00;
  localparam logic [6:0] STL = 7'h40;
  localparam logic [6:0] HLT = 7'h20;
  localparam logic [6:0] RST = 7'h10;
  localparam logic [6:0] CAL = 7'h08;
  localparam logic [6:0] JMP = 7'h04;
  localparam logic [6:0] RET = 7'h02;
  localparam logic [6:0] BR  = 7'h01;

  // Flags after the edge: {halted, ras_empty, ras_full, ras_underflow}
  typedef struct {
    logic [6:0] req;
    logic [7:0] bt;
    logic [7:0] jt;
    logic [7:0] nxt;
    logic [7:0] pc;
    logic [3:0] flg;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_seq_if #(.PC_WIDTH(W)) bus ();

  pc_sequencer #(
    .PC_WIDTH  (W),
    .RESET_PC  (8'h00),
    .PC_INC    (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic vec_t v(input logic [6:0] req, input int bt, input int jt,
                             input int nxt, input int pc, input logic [3:0] flg);
    vec_t r;
    r.req = req;
    r.bt  = 8'(bt);
    r.jt  = 8'(jt);
    r.nxt = 8'(nxt);
    r.pc  = 8'(pc);
    r.flg = flg;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] req, input logic [7:0] bt, input logic [7:0] jt);
    bus.stall         = req[6];
    bus.halt          = req[5];
    bus.restart       = req[4];
    bus.call          = req[3];
    bus.jump          = req[2];
    bus.ret           = req[1];
    bus.branch_taken  = req[0];
    bus.branch_target = bt;
    bus.jump_target   = jt;
  endtask

  function automatic logic [7:0] flags();
    return {4'b0, bus.halted, bus.ras_empty, bus.ras_full, bus.ras_underflow};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / increment
    vecs.push_back(v(N, 0, 0, 1, 1, 4'b0100));
    vecs.push_back(v(N, 0, 0, 2, 2, 4'b0100));
    vecs.push_back(v(N, 0, 0, 3, 3, 4'b0100));
    vecs.push_back(v(N, 0, 0, 4, 4, 4'b0100));
    // Priority
    vecs.push_back(v(JMP,      0, 10, 10, 10, 4'b0100));
    vecs.push_back(v(BR | JMP, 40, 80, 80, 80, 4'b0100));
    vecs.push_back(v(BR,       40, 0, 40, 40, 4'b0100));
    vecs.push_back(v(STL | JMP, 0, 90, 40, 40, 4'b0100));
    // Call/ret nesting
    vecs.push_back(v(JMP, 0, 5,   5,   5,   4'b0100));
    vecs.push_back(v(CAL, 0, 100, 100, 100, 4'b0000));
    vecs.push_back(v(CAL, 0, 200, 200, 200, 4'b0000));
    vecs.push_back(v(RET, 0, 0,   101, 101, 4'b0000));
    vecs.push_back(v(RET, 0, 0,   6,   6,   4'b0100));
    // call+ret pushes only; ret+branch pops only
    vecs.push_back(v(CAL | RET, 0, 50, 50, 50, 4'b0000));
    vecs.push_back(v(RET | BR, 60, 0, 7,  7,  4'b0100));
    // Overflow then underflow
    vecs.push_back(v(JMP, 0, 1,  1,  1,  4'b0100));
    vecs.push_back(v(CAL, 0, 11, 11, 11, 4'b0000));
    vecs.push_back(v(CAL, 0, 21, 21, 21, 4'b0000));
    vecs.push_back(v(CAL, 0, 31, 31, 31, 4'b0000));
    vecs.push_back(v(CAL, 0, 41, 41, 41, 4'b0010));
    vecs.push_back(v(CAL, 0, 51, 51, 51, 4'b0010));
    vecs.push_back(v(RET, 0, 0,  42, 42, 4'b0000));
    vecs.push_back(v(RET, 0, 0,  32, 32, 4'b0000));
    vecs.push_back(v(RET, 0, 0,  22, 22, 4'b0000));
    vecs.push_back(v(RET, 0, 0,  12, 12, 4'b0100));
    vecs.push_back(v(RET, 0, 0,  13, 13, 4'b0101));
    vecs.push_back(v(N,   0, 0,  14, 14, 4'b0101));
    vecs.push_back(v(STL | RET, 0, 0, 14, 14, 4'b0101));
    // Halt / restart (one stacked entry to prove restart clears it)
    vecs.push_back(v(CAL,       0, 7,  7, 7, 4'b0001));
    vecs.push_back(v(HLT,       0, 0,  8, 8, 4'b1001));
    vecs.push_back(v(JMP,       0, 99, 8, 8, 4'b1001));
    vecs.push_back(v(CAL,       0, 99, 8, 8, 4'b1001));
    vecs.push_back(v(RET,       0, 0,  8, 8, 4'b1001));
    vecs.push_back(v(HLT | JMP, 0, 99, 8, 8, 4'b1001));
    vecs.push_back(v(N,         0, 0,  8, 8, 4'b1001));
    vecs.push_back(v(RST,       0, 0,  0, 0, 4'b0100));
    // restart in RUN ignored; halt under stall ignored
    vecs.push_back(v(RST,       0, 0,  1, 1, 4'b0100));
    vecs.push_back(v(HLT | STL, 0, 0,  1, 1, 4'b0100));
    // Wrap-around
    vecs.push_back(v(JMP, 0, 255, 255, 255, 4'b0100));
    vecs.push_back(v(N,   0, 0,   0,   0,   4'b0100));
    vecs.push_back(v(N,   0, 0,   1,   1,   4'b0100));

    drive(N, 8'd0, 8'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", bus.pc, 8'd0);
    check("reset_flags", flags(), 8'b0100);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].bt, vecs[i].jt);
      #1;
      check($sformatf("pc_next[%0d]", i), bus.pc_next, vecs[i].nxt);
      @(posedge clk);
      #1;
      check($sformatf("pc[%0d]", i), bus.pc, vecs[i].pc);
      check($sformatf("flags[%0d]", i), flags(), {4'b0, vecs[i].flg});
    end

    // Async reset between edges while a call is requested (pc is 1 here)
    drive(CAL, 8'd0, 8'd123);
    #1;
    check("call_pc_next", bus.pc_next, 8'd123);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_pc", bus.pc, 8'd0);
    check("async_reset_flags", flags(), 8'b0100);
    @(posedge clk);
    #1;
    check("reset_held_pc", bus.pc, 8'd0);
    drive(N, 8'd0, 8'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_pc", bus.pc, 8'd1);
    check("post_reset_flags", flags(), 8'b0100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
